// File: rtl/decrypt_pkg.sv
// Shared types and constants for the Avalon-MM decrypt master.
package decrypt_pkg;

  localparam int NUM_WR_WORDS = 8;
  localparam int NUM_RD_WORDS = 4;

  typedef logic [127:0] block_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/decrypt_word_mux.sv
// Selects one 32-bit word out of a 128-bit block; word 0 is the least significant.
module decrypt_word_mux
  import decrypt_pkg::*;
(
  input  block_t      blk,
  input  logic [1:0]  idx,
  output logic [31:0] word
);

  always_comb begin
    word = blk[{idx, 5'd0} +: 32];
  end

endmodule

// File: rtl/avalon_decrypt_master.sv
// Feeds a ciphertext/key pair to hw_decrypt over Avalon-MM and reads back the plaintext.
// Optional stall watchdog is compiled in when DECRYPT_MASTER_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | waiting for a ciphertext/key pair
// WRITE | issuing the 8 command words (ct then key, low word first)
// READ  | collecting the 4 plaintext words
// DONE  | presenting out_pt until the consumer takes it
module avalon_decrypt_master
  import decrypt_pkg::*;
#(
  parameter logic WR_ADDR     = 1'b1,
  parameter logic RD_ADDR     = 1'b1,
  parameter int   TIMEOUT_CYC = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_ct,
  input  logic [127:0] in_key,
  output logic         address,
  output logic         write,
  output logic         read,
  output logic [31:0]  writedata,
  input  logic [31:0]  readdata,
  input  logic         waitrequest,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_pt,
  output logic         out_err
);

  if (TIMEOUT_CYC < 2) begin : g_cfg_check
    $error("TIMEOUT_CYC must be at least 2");
  end

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  block_t      ct_q, ct_d;
  block_t      key_q, key_d;
  block_t      pt_q, pt_d;
  logic        alive_q;
  logic [31:0] ct_word, key_word;

`ifdef DECRYPT_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  decrypt_word_mux u_ct_mux (
    .blk  (ct_q),
    .idx  (wcnt_q[1:0]),
    .word (ct_word)
  );

  decrypt_word_mux u_key_mux (
    .blk  (key_q),
    .idx  (wcnt_q[1:0]),
    .word (key_word)
  );

  // alive_q holds in_ready low until the first edge after reset release
  always_comb begin
    in_ready  = alive_q && (state_q == IDLE);
    write     = (state_q == WRITE);
    read      = (state_q == READ);
    address   = 1'b0;
    writedata = 32'h0;
    if (write) begin
      address   = WR_ADDR;
      writedata = wcnt_q[2] ? key_word : ct_word;
    end else if (read) begin
      address = RD_ADDR;
    end
    out_valid = (state_q == DONE);
    out_pt    = pt_q;
`ifdef DECRYPT_MASTER_TIMEOUT_EN
    out_err   = err_q;
`else
    out_err   = 1'b0;
`endif
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    ct_d    = ct_q;
    key_d   = key_q;
    pt_d    = pt_q;
`ifdef DECRYPT_MASTER_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          ct_d    = in_ct;
          key_d   = in_key;
          pt_d    = '0;
          wcnt_d  = '0;
          state_d = WRITE;
`ifdef DECRYPT_MASTER_TIMEOUT_EN
          tmo_d   = TMO_LOAD;
          err_d   = 1'b0;
`endif
        end
      end
      WRITE: begin
        if (!waitrequest) begin
          if (wcnt_q == 4'(NUM_WR_WORDS - 1)) begin
            wcnt_d  = '0;
            state_d = READ;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      READ: begin
        if (!waitrequest) begin
          pt_d[{wcnt_q[1:0], 5'd0} +: 32] = readdata;
          if (wcnt_q == 4'(NUM_RD_WORDS - 1)) begin
            wcnt_d  = '0;
            state_d = DONE;
          end else begin
            wcnt_d = wcnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          wcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef DECRYPT_MASTER_TIMEOUT_EN
    // Watchdog counts down over consecutive stalled cycles and overrides the beat logic
    if (state_q == WRITE || state_q == READ) begin
      if (!waitrequest) begin
        tmo_d = TMO_LOAD;
      end else if (tmo_q == '0) begin
        state_d = DONE;
        wcnt_d  = '0;
        pt_d    = '0;
        err_d   = 1'b1;
      end else begin
        tmo_d = tmo_q - 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      ct_q    <= '0;
      key_q   <= '0;
      pt_q    <= '0;
      alive_q <= 1'b0;
`ifdef DECRYPT_MASTER_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ct_q    <= ct_d;
      key_q   <= key_d;
      pt_q    <= pt_d;
      alive_q <= 1'b1;
`ifdef DECRYPT_MASTER_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_avalon_decrypt_master.sv
// Self-checking bench for avalon_decrypt_master with a behavioural Avalon slave and reference model.
module tb_avalon_decrypt_master;

  localparam logic WR_A = 1'b1;
  localparam logic RD_A = 1'b1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_ct = '0;
  logic [127:0] in_key = '0;
  logic         address;
  logic         write;
  logic         read;
  logic [31:0]  writedata;
  logic [31:0]  readdata = '0;
  logic         waitrequest = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] out_pt;
  logic         out_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  avalon_decrypt_master #(
    .WR_ADDR     (WR_A),
    .RD_ADDR     (RD_A),
    .TIMEOUT_CYC (256)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_ct       (in_ct),
    .in_key      (in_key),
    .address     (address),
    .write       (write),
    .read        (read),
    .writedata   (writedata),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pt      (out_pt),
    .out_err     (out_err)
  );

  function automatic logic [31:0] word_of(input logic [127:0] blk, input int k);
    return 32'(blk >> (32 * k));
  endfunction

  // Waits at negedges for in_ready and offers one pair; returns with cycle 1 current.
  task automatic offer(input logic [127:0] ct, input logic [127:0] key);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL offer_in_ready: got %b want 1", in_ready);
    end
    in_ct    = ct;
    in_key   = key;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Full transaction against the slave model; lat = cycle of first out_valid (accept = cycle 0).
  task automatic run_txn(input logic [127:0] ct, input logic [127:0] key, input logic [127:0] rd_blk,
                         input int stall_pct, input int stall_word, input int stall_len,
                         input int hold_rdy, input bit noisy, output int lat);
    logic [31:0]  wr_seen[$];
    logic [31:0]  prev_wd;
    logic [127:0] prev_pt;
    logic [31:0]  exp_w;
    bit           prev_stall, seen_done, finished;
    int           cyc, nrd, stall_left, done_cnt;
    lat = -1; prev_stall = 0; seen_done = 0; finished = 0;
    nrd = 0; stall_left = stall_len; done_cnt = 0; prev_wd = '0; prev_pt = '0;
    waitrequest = 1'b0;
    out_ready = 1'b0;
    offer(ct, key);
    cyc = 1;
    while (cyc < 3000 && !finished) begin
      checks++;
      if (write && read) begin
        errors++;
        $display("FAIL both_strobes: cycle %0d write=%b read=%b", cyc, write, read);
      end
      if (write || read) begin
        checks++;
        if (in_ready !== 1'b0 || address !== (write ? WR_A : RD_A)) begin
          errors++;
          $display("FAIL busy_outputs: cycle %0d in_ready=%b address=%b", cyc, in_ready, address);
        end
      end
      if (write) begin
        if (prev_stall) begin
          checks++;
          if (writedata !== prev_wd) begin
            errors++;
            $display("FAIL wd_hold: got %h want %h", writedata, prev_wd);
          end
        end
        if (stall_word == wr_seen.size() && stall_left > 0) begin
          waitrequest = 1'b1;
          stall_left--;
        end else begin
          waitrequest = ($urandom_range(99) < stall_pct);
        end
        if (!waitrequest) wr_seen.push_back(writedata);
        prev_stall = waitrequest;
        prev_wd    = writedata;
      end else if (read) begin
        prev_stall  = 0;
        waitrequest = ($urandom_range(99) < stall_pct);
        if (!waitrequest && nrd < 4) begin
          readdata = word_of(rd_blk, nrd);
          nrd++;
        end
      end else begin
        prev_stall  = 0;
        waitrequest = 1'($urandom_range(1));
      end
      if (noisy) begin
        in_valid = 1'($urandom_range(1));
        in_ct    = {$urandom, $urandom, $urandom, $urandom};
      end
      if (out_valid) begin
        checks++;
        if (!seen_done) begin
          lat = cyc;
          seen_done = 1;
          if (out_pt !== rd_blk || out_err !== 1'b0) begin
            errors++;
            $display("FAIL out_pt: got %h err=%b want %h err=0", out_pt, out_err, rd_blk);
          end
        end else if (out_pt !== prev_pt) begin
          errors++;
          $display("FAIL pt_stable: got %h want %h", out_pt, prev_pt);
        end
        checks++;
        if (in_ready !== 1'b0 || write !== 1'b0 || read !== 1'b0) begin
          errors++;
          $display("FAIL done_quiet: in_ready=%b write=%b read=%b want 0 0 0", in_ready, write, read);
        end
        prev_pt   = out_pt;
        out_ready = (done_cnt >= hold_rdy);
        done_cnt++;
        if (out_ready) begin
          in_valid = 1'b0;
          finished = 1;
        end
      end else begin
        if (seen_done) begin
          checks++;
          errors++;
          $display("FAIL valid_dropped: out_valid=%b before handshake", out_valid);
        end
        out_ready = 1'($urandom_range(1));
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL txn_timeout: no handshake within %0d cycles", cyc);
    end else if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_handshake: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    checks++;
    if (wr_seen.size() != 8 || nrd != 4) begin
      errors++;
      $display("FAIL beat_count: writes=%0d reads=%0d want 8 4", wr_seen.size(), nrd);
    end
    for (int i = 0; i < 8 && i < wr_seen.size(); i++) begin
      exp_w = (i < 4) ? word_of(ct, i) : word_of(key, i - 4);
      checks++;
      if (wr_seen[i] !== exp_w) begin
        errors++;
        $display("FAIL wr_word%0d: got %h want %h", i, wr_seen[i], exp_w);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({write, read, address, writedata, out_valid, out_err, out_pt, in_ready} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: w=%b r=%b a=%b wd=%h ov=%b oe=%b pt=%h ir=%b want all 0",
               write, read, address, writedata, out_valid, out_err, out_pt, in_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || write !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: in_ready=%b write=%b want 0 0", in_ready, write);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_early: got %b want 0", in_ready);
    end
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vector();
    int lat;
    run_txn(128'h91f025e0e77340570cf1931a70918058, 128'h123456789abcdef0aabbccddeeff0011,
            128'hccddeeff8899aabb4455667700112233, 0, -1, 0, 0, 0, lat);
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL vector_latency: got %0d want 13", lat);
    end
  endtask

  task automatic test_stall_word();
    int lat;
    run_txn(128'h91f025e0e77340570cf1931a70918058, 128'h123456789abcdef0aabbccddeeff0011,
            128'h0123456789abcdeffedcba9876543210, 0, 4, 3, 0, 0, lat);
    checks++;
    if (lat != 16) begin
      errors++;
      $display("FAIL stall_latency: got %0d want 16", lat);
    end
  endtask

  task automatic test_out_hold();
    int lat;
    run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, 5, 0, lat);
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL hold_latency: got %0d want 13", lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int t = 0; t < 4; t++) begin
      run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 0, -1, 0, 0, 1, lat);
      checks++;
      if (lat != 13) begin
        errors++;
        $display("FAIL b2b_latency%0d: got %0d want 13", t, lat);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    for (int t = 0; t < 12; t++) begin
      run_txn({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom}, 40, -1, 0,
              int'($urandom_range(3)), 1, lat);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    waitrequest = 1'b0;
    offer(128'hdeadbeef_cafef00d_01020304_05060708, 128'h11111111_22222222_33333333_44444444);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({write, read, address, writedata, in_ready, out_valid} !== '0) begin
      errors++;
      $display("FAIL mid_reset: w=%b r=%b a=%b wd=%h ir=%b ov=%b want all 0",
               write, read, address, writedata, in_ready, out_valid);
    end
    @(negedge clk);
    checks++;
    if (write !== 1'b0 || read !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_hold: write=%b read=%b want 0 0", write, read);
    end
    reset = 1'b1;
    @(negedge clk);
    run_txn(128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'hffeeddcc_bbaa9988_77665544_33221100,
            128'ha5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c, 0, -1, 0, 0, 0, lat);
    checks++;
    if (lat != 13) begin
      errors++;
      $display("FAIL restart_latency: got %0d want 13", lat);
    end
  endtask

  task automatic test_stuck();
    int cyc;
    waitrequest = 1'b1;
    out_ready   = 1'b0;
    offer({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    waitrequest = 1'b1;
    cyc = 1;
`ifdef DECRYPT_MASTER_TIMEOUT_EN
    while (!out_valid && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 257 || out_err !== 1'b1 || out_pt !== '0 || write !== 1'b0) begin
      errors++;
      $display("FAIL watchdog: cycle=%0d err=%b pt=%h write=%b want 257 1 0 0", cyc, out_err, out_pt, write);
    end
`else
    while (cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (write !== 1'b1 || out_valid !== 1'b0 || out_err !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stuck_write: write=%b ov=%b err=%b ir=%b want 1 0 0 0", write, out_valid, out_err, in_ready);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    waitrequest = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_vector();
    test_stall_word();
    test_out_hold();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stuck();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
